// File: rtl/boron_pkg.sv
`default_nettype none
//============================================================================
// Module      : boron_pkg
// Description : Shared definitions for the Boron block decryptor: S-box
//               tables, per-word rotation amounts, default round count,
//               FSM state encoding and a 16-bit rotate helper.
// Revision    : 1.0 - initial release
//============================================================================
package boron_pkg;

   localparam int DEFAULT_ROUNDS = 25;

   // Per-word rotation amounts of the forward round (left); the inverse
   // round rotates right by the same amounts.
   localparam int ROT_W0 = 1;
   localparam int ROT_W1 = 4;
   localparam int ROT_W2 = 7;
   localparam int ROT_W3 = 9;

   localparam logic [3:0] SBOX [16] = '{
      4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
      4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
   };

   localparam logic [3:0] INV_SBOX [16] = '{
      4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
      4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Rotate a 16-bit word right by a constant amount (1..15).
   function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
      return (x >> n) | (x << (16 - n));
   endfunction

endpackage : boron_pkg
`default_nettype wire

// File: rtl/boron_inv_round.sv
`default_nettype none
//============================================================================
// Module      : boron_inv_round
// Description : One combinational Boron inverse round:
//               unmix (W1^=W0, W3^=W2), rotate right, byte swap,
//               inverse S-box on every nibble, key XOR.
// Ports       : state_i [63:0] - input state {W3,W2,W1,W0}
//               key_i   [63:0] - round key
//               state_o [63:0] - output state
// Revision    : 1.0 - initial release
//============================================================================
module boron_inv_round
   import boron_pkg::*;
(
   input  logic [63:0] state_i,
   input  logic [63:0] key_i,
   output logic [63:0] state_o
);

   logic [15:0] w_mix [4];
   logic [15:0] w_rot [4];
   logic [63:0] w_swap;
   logic [63:0] w_sub;

   always_comb begin
      // Forward mixing ran W1^=W0 then W3^=W2; W0 and W2 are untouched by
      // it, so both XORs undo independently on the incoming words.
      w_mix[0] = state_i[15:0];
      w_mix[1] = state_i[31:16] ^ state_i[15:0];
      w_mix[2] = state_i[47:32];
      w_mix[3] = state_i[63:48] ^ state_i[47:32];

      w_rot[0] = rotr16(w_mix[0], ROT_W0);
      w_rot[1] = rotr16(w_mix[1], ROT_W1);
      w_rot[2] = rotr16(w_mix[2], ROT_W2);
      w_rot[3] = rotr16(w_mix[3], ROT_W3);

      w_swap = {w_rot[3][7:0], w_rot[3][15:8],
                w_rot[2][7:0], w_rot[2][15:8],
                w_rot[1][7:0], w_rot[1][15:8],
                w_rot[0][7:0], w_rot[0][15:8]};

      w_sub = '0;
      for (int i = 0; i < 16; i++) begin
         w_sub[i*4 +: 4] = INV_SBOX[w_swap[i*4 +: 4]];
      end

      state_o = w_sub ^ key_i;
   end

endmodule : boron_inv_round
`default_nettype wire

// File: rtl/boron_dec_core.sv
`default_nettype none
//============================================================================
// Module      : boron_dec_core
// Description : Iterative Boron block decryptor, one inverse round per
//               clock, round keys fetched from an external key store.
// Ports       : clk, rst              - clock / async active-high reset
//               in_valid/in_ready     - ciphertext handshake
//               in_data   [63:0]      - ciphertext {W3,W2,W1,W0}
//               rk_idx    [4:0]       - round-key index (state decode)
//               rk_data   [63:0]      - round key for rk_idx, same cycle
//               out_valid/out_ready   - plaintext handshake
//               out_data  [63:0]      - plaintext
// Revision    : 1.0 - initial release
//============================================================================
module boron_dec_core
   import boron_pkg::*;
#(
   parameter int ROUNDS = DEFAULT_ROUNDS
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic [4:0]  rk_idx,
   input  logic [63:0] rk_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data
);

   localparam logic [4:0] C_LAST_IDX  = 5'(ROUNDS);
   localparam logic [4:0] C_FIRST_RND = 5'(ROUNDS - 1);

   state_e      st_q,  st_d;
   logic [4:0]  rnd_q, rnd_d;
   logic [63:0] blk_q, blk_d;
   logic [63:0] w_round_out;

   boron_inv_round u_inv_round (
      .state_i (blk_q),
      .key_i   (rk_data),
      .state_o (w_round_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q  <= ST_IDLE;
         rnd_q <= '0;
         blk_q <= '0;
      end else begin
         st_q  <= st_d;
         rnd_q <= rnd_d;
         blk_q <= blk_d;
      end
   end

   always_comb begin
      st_d      = st_q;
      rnd_d     = rnd_q;
      blk_d     = blk_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      rk_idx    = C_LAST_IDX;

      case (st_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            rk_idx   = C_LAST_IDX;
            // Load only on a real accept so an undriven bus never reaches
            // the state register.
            if (in_valid) begin
               blk_d = in_data ^ rk_data;
               rnd_d = C_FIRST_RND;
               st_d  = ST_ROUND;
            end
         end
         ST_ROUND: begin
            rk_idx = rnd_q;
            blk_d  = w_round_out;
            if (rnd_q == 5'd0) begin
               st_d = ST_DONE;
            end else begin
               rnd_d = rnd_q - 5'd1;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            out_data  = blk_q;
            rk_idx    = 5'd0;
            if (out_ready) begin
               st_d = ST_IDLE;
            end
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

endmodule : boron_dec_core
`default_nettype wire

// File: tb/tb_boron_dec_core.sv
`default_nettype none
//============================================================================
// Module      : tb_boron_dec_core
// Description : Self-checking bench for boron_dec_core. Two instances:
//               ROUNDS=1 (known-answer) and ROUNDS=25 (random vectors
//               encrypted by a forward reference model).
// Revision    : 1.0 - initial release
//============================================================================
module tb_boron_dec_core;

   localparam int R_A = 1;
   localparam int R_B = 25;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A (ROUNDS=1)
   logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0;
   logic [63:0] in_data_a = '0, rk_data_a, out_data_a;
   logic [4:0]  rk_idx_a;
   logic [63:0] keys_a [0:R_A];

   // Instance B (ROUNDS=25)
   logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0;
   logic [63:0] in_data_b = '0, rk_data_b, out_data_b;
   logic [4:0]  rk_idx_b;
   logic [63:0] keys_b [0:R_B];

   always_comb rk_data_a = (int'(rk_idx_a) <= R_A) ? keys_a[rk_idx_a] : 64'd0;
   always_comb rk_data_b = (int'(rk_idx_b) <= R_B) ? keys_b[rk_idx_b] : 64'd0;

   boron_dec_core #(.ROUNDS(R_A)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .rk_idx(rk_idx_a), .rk_data(rk_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a)
   );

   boron_dec_core #(.ROUNDS(R_B)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .rk_idx(rk_idx_b), .rk_data(rk_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model (forward cipher) ----------------
   logic [3:0] ref_sbox [16] = '{4'hE,4'h4,4'hB,4'h1,4'h7,4'h9,4'hC,4'hA,
                                 4'hD,4'h2,4'h0,4'hF,4'h8,4'h5,4'h3,4'h6};
   int ref_rot [4] = '{1, 4, 7, 9};

   function automatic logic [63:0] encrypt(input logic [63:0] p);
      logic [63:0] s;
      logic [15:0] w [4];
      s = p;
      for (int r = 0; r < R_B; r++) begin
         s = s ^ keys_b[r];
         for (int n = 0; n < 16; n++) s[n*4 +: 4] = ref_sbox[s[n*4 +: 4]];
         for (int k = 0; k < 4; k++) begin
            w[k] = s[k*16 +: 16];
            w[k] = {w[k][7:0], w[k][15:8]};
            w[k] = (w[k] << ref_rot[k]) | (w[k] >> (16 - ref_rot[k]));
         end
         w[1] = w[1] ^ w[0];
         w[3] = w[3] ^ w[2];
         s = {w[3], w[2], w[1], w[0]};
      end
      return s ^ keys_b[R_B];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_keys_b;
      for (int i = 0; i <= R_B; i++) keys_b[i] = {$urandom, $urandom};
   endtask

   // Feed one ciphertext to B (must be in IDLE), wait for DONE.
   // Returns edges from accept to out_valid.
   task automatic run_b(input logic [63:0] c, output int lat);
      in_data_b  = c;
      in_valid_b = 1'b1;
      tick;
      in_valid_b = 1'b0;
      in_data_b  = 'x;
      lat = 0;
      while (!out_valid_b && lat < 60) begin
         tick;
         lat++;
      end
   endtask

   task automatic release_b;
      out_ready_b = 1'b1;
      tick;
      out_ready_b = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      tick; tick;
      n_checks++;
      if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_data_a !== 64'd0 || rk_idx_a !== 5'd1) begin
         n_fail++;
         $display("FAIL reset_a: in_ready=%b out_valid=%b out_data=%h rk_idx=%0d, want 1 0 0 1",
                  in_ready_a, out_valid_a, out_data_a, rk_idx_a);
      end
      n_checks++;
      if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || out_data_b !== 64'd0 || rk_idx_b !== 5'd25) begin
         n_fail++;
         $display("FAIL reset_b: in_ready=%b out_valid=%b out_data=%h rk_idx=%0d, want 1 0 0 25",
                  in_ready_b, out_valid_b, out_data_b, rk_idx_b);
      end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_known_answer_r1;
      int lat;
      for (int i = 0; i <= R_A; i++) keys_a[i] = 64'd0;
      in_data_a  = 64'd0;
      in_valid_a = 1'b1;
      tick;
      in_valid_a = 1'b0;
      lat = 0;
      while (!out_valid_a && lat < 10) begin
         tick;
         lat++;
      end
      n_checks++;
      if (lat !== R_A) begin
         n_fail++;
         $display("FAIL kat_latency: edges after accept=%0d, want %0d", lat, R_A);
      end
      n_checks++;
      if (out_data_a !== 64'hAAAA_AAAA_AAAA_AAAA) begin
         n_fail++;
         $display("FAIL kat_data: got %h, want aaaaaaaaaaaaaaaa", out_data_a);
      end
      out_ready_a = 1'b1;
      tick;
      out_ready_a = 1'b0;
      n_checks++;
      if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
         n_fail++;
         $display("FAIL kat_return_idle: in_ready=%b out_valid=%b, want 1 0", in_ready_a, out_valid_a);
      end
   endtask

   task automatic test_random_vectors;
      logic [63:0] p;
      int lat;
      for (int v = 0; v < 1000; v++) begin
         randomize_keys_b;
         if (v == 0)      p = 64'd0;
         else if (v == 1) p = 64'hFFFF_FFFF_FFFF_FFFF;
         else             p = {$urandom, $urandom};
         run_b(encrypt(p), lat);
         n_checks++;
         if (lat !== R_B || out_data_b !== p) begin
            n_fail++;
            $display("FAIL vector_%0d: data=%h latency=%0d, want data=%h latency=%0d",
                     v, out_data_b, lat, p, R_B);
         end
         release_b;
      end
   endtask

   task automatic test_rk_trace;
      randomize_keys_b;
      in_data_b  = {$urandom, $urandom};
      in_valid_b = 1'b1;
      n_checks++;
      if (rk_idx_b !== 5'd25) begin
         n_fail++;
         $display("FAIL rk_accept: rk_idx=%0d, want 25", rk_idx_b);
      end
      tick;
      in_valid_b = 1'b0;
      for (int k = R_B - 1; k >= 0; k--) begin
         n_checks++;
         if (rk_idx_b !== 5'(k)) begin
            n_fail++;
            $display("FAIL rk_round: rk_idx=%0d, want %0d", rk_idx_b, k);
         end
         tick;
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (rk_idx_b !== 5'd0 || out_valid_b !== 1'b1) begin
            n_fail++;
            $display("FAIL rk_done: rk_idx=%0d out_valid=%b, want 0 1", rk_idx_b, out_valid_b);
         end
         tick;
      end
      release_b;
   endtask

   task automatic test_stall;
      logic [63:0] p;
      int lat;
      randomize_keys_b;
      p = {$urandom, $urandom};
      run_b(encrypt(p), lat);
      for (int k = 0; k < 10; k++) begin
         if (k == 4) begin
            in_valid_b = 1'b1;
            in_data_b  = {$urandom, $urandom};
         end
         if (k == 5) in_valid_b = 1'b0;
         n_checks++;
         if (out_valid_b !== 1'b1 || out_data_b !== p || in_ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_%0d: out_valid=%b out_data=%h in_ready=%b, want 1 %h 0",
                     k, out_valid_b, out_data_b, in_ready_b, p);
         end
         tick;
      end
      release_b;
      n_checks++;
      if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || rk_idx_b !== 5'd25) begin
         n_fail++;
         $display("FAIL stall_release: in_ready=%b out_valid=%b rk_idx=%0d, want 1 0 25",
                  in_ready_b, out_valid_b, rk_idx_b);
      end
      // The ignored pulse must not have started a block.
      tick;
      n_checks++;
      if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_pulse_ignored: in_ready=%b out_valid=%b, want 1 0", in_ready_b, out_valid_b);
      end
   endtask

   task automatic test_async_reset;
      logic [63:0] p;
      int lat;
      randomize_keys_b;
      in_data_b  = {$urandom, $urandom};
      in_valid_b = 1'b1;
      tick;
      in_valid_b = 1'b0;
      for (int k = 0; k < 12; k++) tick;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || out_data_b !== 64'd0 || rk_idx_b !== 5'd25) begin
         n_fail++;
         $display("FAIL async_reset: in_ready=%b out_valid=%b out_data=%h rk_idx=%0d, want 1 0 0 25",
                  in_ready_b, out_valid_b, out_data_b, rk_idx_b);
      end
      tick;
      rst = 1'b0;
      tick;
      p = {$urandom, $urandom};
      run_b(encrypt(p), lat);
      n_checks++;
      if (lat !== R_B || out_data_b !== p) begin
         n_fail++;
         $display("FAIL after_reset_block: data=%h latency=%0d, want %h %0d", out_data_b, lat, p, R_B);
      end
      release_b;
   endtask

   task automatic test_back_to_back;
      logic [63:0] p1, p2;
      logic [63:0] got [$];
      int acc [$];
      int cyc;
      randomize_keys_b;
      p1 = {$urandom, $urandom};
      p2 = {$urandom, $urandom};
      in_data_b   = encrypt(p1);
      in_valid_b  = 1'b1;
      out_ready_b = 1'b1;
      cyc = 0;
      while (got.size() < 2 && cyc < 100) begin
         if (in_valid_b && in_ready_b) acc.push_back(cyc);
         if (out_valid_b) got.push_back(out_data_b);
         tick;
         cyc++;
         if (acc.size() == 1) in_data_b = encrypt(p2);
         if (acc.size() == 2) in_valid_b = 1'b0;
      end
      in_valid_b  = 1'b0;
      out_ready_b = 1'b0;
      n_checks++;
      if (acc.size() != 2 || got.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_counts: accepts=%0d outputs=%0d, want 2 2", acc.size(), got.size());
      end else begin
         n_checks++;
         if (acc[1] - acc[0] != R_B + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d cycles, want %0d", acc[1] - acc[0], R_B + 2);
         end
         n_checks++;
         if (got[0] !== p1 || got[1] !== p2) begin
            n_fail++;
            $display("FAIL b2b_data: got %h %h, want %h %h", got[0], got[1], p1, p2);
         end
      end
      tick;
   endtask

   initial begin
      for (int i = 0; i <= R_A; i++) keys_a[i] = 64'd0;
      for (int i = 0; i <= R_B; i++) keys_b[i] = 64'd0;
      test_reset;
      test_known_answer_r1;
      test_rk_trace;
      test_stall;
      test_async_reset;
      test_back_to_back;
      test_random_vectors;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_boron_dec_core
`default_nettype wire

// File: doc/boron_dec_core.md
Name: boron_dec_core

Overview:
Iterative Boron block decryptor. It takes a 64-bit ciphertext and produces a 64-bit plaintext, running one inverse round per clock. It is the receive-side counterpart of the encryption datapath built around the 16-bit per-word byte-swap shuffle. Round keys come from an external key store through an index/data port. Valid/ready streaming handshakes are used on input and output.

Parameters:
ROUNDS, 25, number of inverse rounds. Legal range 1..31. The key store holds ROUNDS+1 round keys, indices 0..ROUNDS.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ciphertext valid
in_ready  output  1  core can accept ciphertext
in_data  input  64  ciphertext {W3,W2,W1,W0}, 16-bit words
rk_idx  output  5  round-key index requested this cycle
rk_data  input  64  round key for rk_idx, combinational, same cycle
out_valid  output  1  plaintext valid
out_ready  input  1  downstream accepts plaintext
out_data  output  64  plaintext

Behaviour:
- Forward round, as the team defines it (reference only):
  - XOR the 64-bit key.
  - Apply the S-box to each of the 16 nibbles.
  - Swap the two bytes of each word: {n3,n2,n1,n0} -> {n1,n0,n3,n2}.
  - Rotate left: W0 by 1, W1 by 4, W2 by 7, W3 by 9.
  - W1 ^= W0, then W3 ^= W2.
  - After ROUNDS rounds, XOR key[ROUNDS].
- Inverse round invround(S,K), purely combinational, in this order:
  - W1 ^= W0, then W3 ^= W2.
  - Rotate right: W0 by 1, W1 by 4, W2 by 7, W3 by 9.
  - Swap the two bytes of each word (self-inverse).
  - Apply the inverse S-box to each nibble.
  - XOR K.
- S-box, index 0..F: E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6.
- Inverse S-box, index 0..F: A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=ROUNDS.
  - On in_valid: state <= in_data ^ rk_data, rnd <= ROUNDS-1, go to ROUND.
- ROUND:
  - in_ready=0, rk_idx=rnd.
  - Each cycle: state <= invround(state, rk_data).
  - If rnd==0, go to DONE; otherwise rnd <= rnd-1.
- DONE:
  - out_valid=1, out_data=state, rk_idx=0, in_ready=0.
  - On out_ready, go to IDLE.
  - out_data and out_valid are held stable while stalled.
- Latency: accept at edge T; out_valid is high in the cycle after edge T+ROUNDS. Exactly ROUNDS+1 clocks from accept to output.
- Throughput: one block per ROUNDS+2 cycles when out_ready is held high.
- No overlap: a new input is accepted only in IDLE. The DONE->IDLE transition and a new accept never occur in the same cycle.
- rk_idx is a registered-state decode. rk_data is sampled only at the advancing edge.
- Reset, including mid-operation, forces:
  - state=IDLE, rnd=0, internal state register=0.
  - out_valid=0, out_data=0, in_ready=1 (IDLE decode), rk_idx=ROUNDS.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- X on in_data while in_valid=0 must not propagate to the state register.

Decomposition:
- boron_pkg holds:
  - SBOX and INV_SBOX as 16x4 constant arrays.
  - Rotation constants ROT_W0=1, ROT_W1=4, ROT_W2=7, ROT_W3=9.
  - DEFAULT_ROUNDS=25.
  - The FSM state enum.
- One sub-module, boron_inv_round: combinational 64-bit state in, 64-bit key in, 64-bit state out. It is instanced once in the core and reusable by a future unrolled decryptor.

Test Plan:
- ROUNDS=1, all keys 0, in_data=0 -> out_data=64'hAAAA_AAAA_AAAA_AAAA, out_valid high exactly 2 clocks after accept.
- ROUNDS=25, random keys and plaintext encrypted by the team's forward model -> decryptor returns the original plaintext, for 1000 vectors including all-0 and all-F.
- out_ready held 0 for 10 cycles in DONE -> out_data and out_valid stable, in_ready=0, a second in_valid pulse ignored. Then out_ready=1 -> IDLE next cycle.
- rk_idx trace for ROUNDS=25 -> 25 on the accept cycle, then 24,23,...,0 on consecutive cycles, then 0 held in DONE.
- rst asserted asynchronously during round 12 -> all outputs at reset values before the next edge. A fresh block after release decrypts correctly.
- Back-to-back inputs with in_valid held 1 -> second block accepted only after DONE->IDLE, spacing ROUNDS+2 cycles, both results correct.
